// File: rtl/cnt_cmd_sched.sv
// Command scheduler that shares one load/up-down counter between two requesters.
// It arbitrates round-robin between A and B and then drives the counter strobes.
// UP and DOWN steps are paced by STEP_GAP idle cycles. Every output is a register.
module cnt_cmd_sched #(
    parameter int STEP_GAP = 0,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [1:0]       cmd_a,
    input  logic [CNT_W-1:0] arg_a,
    output logic             gnt_a,
    output logic             done_a,
    input  logic             req_b,
    input  logic [1:0]       cmd_b,
    input  logic [CNT_W-1:0] arg_b,
    output logic             gnt_b,
    output logic             done_b,
    output logic             ctr_ce,
    output logic             ctr_load,
    output logic             ctr_up,
    output logic [CNT_W-1:0] ctr_data,
    output logic             busy,
    output logic             owner
);

    localparam int GAP_W = 4;
    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_UP   = 2'b01;
    localparam logic [1:0] CMD_DOWN = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_EXEC, S_DONE} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         cmd_reg, cmd_next;
    logic [CNT_W-1:0]   arg_reg, arg_next;
    logic [CNT_W-1:0]   steps_reg, steps_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic               ptr_reg, ptr_next;      // requester favoured on a tie (0 = A)
    logic               owner_reg, owner_next;
    logic               gnt_a_reg, gnt_a_next, gnt_b_reg, gnt_b_next;
    logic               done_a_reg, done_a_next, done_b_reg, done_b_next;
    logic               ce_reg, ce_next, load_reg, load_next, up_reg, up_next;
    logic [CNT_W-1:0]   data_reg, data_next;
    logic               busy_reg, busy_next;
    logic               win;

    // A lone requester wins outright; a tie goes to the favoured requester.
    assign win = (req_a && req_b) ? ptr_reg : req_b;

    // Next state and next output values. The registers below capture them on the clock edge.
    always_comb begin
        state_next  = state_reg;
        cmd_next    = cmd_reg;
        arg_next    = arg_reg;
        steps_next  = steps_reg;
        gap_next    = gap_reg;
        ptr_next    = ptr_reg;
        owner_next  = owner_reg;
        gnt_a_next  = 1'b0;
        gnt_b_next  = 1'b0;
        done_a_next = 1'b0;
        done_b_next = 1'b0;
        ce_next     = 1'b0;
        load_next   = 1'b0;
        up_next     = 1'b0;
        data_next   = '0;
        case (state_reg)
            S_IDLE: begin
                if (req_a || req_b) begin
                    state_next = S_GRANT;
                    owner_next = win;
                    ptr_next   = ~win;
                    gnt_a_next = ~win;
                    gnt_b_next = win;
                    cmd_next   = win ? cmd_b : cmd_a;
                    arg_next   = win ? arg_b : arg_a;
                end
            end
            S_GRANT: begin
                if (cmd_reg == CMD_LOAD) begin
                    state_next = S_EXEC;
                    load_next  = 1'b1;
                    data_next  = arg_reg;
                    steps_next = '0;
                end else if ((cmd_reg == CMD_UP || cmd_reg == CMD_DOWN) && arg_reg != '0) begin
                    // The first step pulse is issued on entry to EXEC.
                    state_next = S_EXEC;
                    ce_next    = 1'b1;
                    up_next    = (cmd_reg == CMD_UP);
                    steps_next = arg_reg - CNT_W'(1);
                    gap_next   = GAP_W'(STEP_GAP);
                end else begin
                    state_next  = S_DONE;
                    done_a_next = ~owner_reg;
                    done_b_next = owner_reg;
                end
            end
            S_EXEC: begin
                if (steps_reg == '0) begin
                    state_next  = S_DONE;
                    done_a_next = ~owner_reg;
                    done_b_next = owner_reg;
                end else begin
                    up_next = (cmd_reg == CMD_UP);
                    if (gap_reg != '0) begin
                        gap_next = gap_reg - GAP_W'(1);
                    end else begin
                        ce_next    = 1'b1;
                        steps_next = steps_reg - CNT_W'(1);
                        gap_next   = GAP_W'(STEP_GAP);
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        busy_next = (state_next != S_IDLE);
    end

    // State and output registers. An active-low reset aborts any command in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            cmd_reg    <= '0;
            arg_reg    <= '0;
            steps_reg  <= '0;
            gap_reg    <= '0;
            ptr_reg    <= 1'b0;
            owner_reg  <= 1'b0;
            gnt_a_reg  <= 1'b0;
            gnt_b_reg  <= 1'b0;
            done_a_reg <= 1'b0;
            done_b_reg <= 1'b0;
            ce_reg     <= 1'b0;
            load_reg   <= 1'b0;
            up_reg     <= 1'b0;
            data_reg   <= '0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cmd_reg    <= cmd_next;
            arg_reg    <= arg_next;
            steps_reg  <= steps_next;
            gap_reg    <= gap_next;
            ptr_reg    <= ptr_next;
            owner_reg  <= owner_next;
            gnt_a_reg  <= gnt_a_next;
            gnt_b_reg  <= gnt_b_next;
            done_a_reg <= done_a_next;
            done_b_reg <= done_b_next;
            ce_reg     <= ce_next;
            load_reg   <= load_next;
            up_reg     <= up_next;
            data_reg   <= data_next;
            busy_reg   <= busy_next;
        end
    end

    assign gnt_a    = gnt_a_reg;
    assign gnt_b    = gnt_b_reg;
    assign done_a   = done_a_reg;
    assign done_b   = done_b_reg;
    assign ctr_ce   = ce_reg;
    assign ctr_load = load_reg;
    assign ctr_up   = up_reg;
    assign ctr_data = data_reg;
    assign busy     = busy_reg;
    assign owner    = owner_reg;

endmodule

// File: tb/tb_cnt_cmd_sched.sv
// Testbench for cnt_cmd_sched. Two instances are built: index 0 has STEP_GAP=0 and index 1 has STEP_GAP=2.
// Each command is expanded into the per-cycle output sequence it should produce.
// The DUT outputs are compared against that sequence every cycle.
module tb_cnt_cmd_sched;

    typedef struct packed {
        logic       gnt_a;
        logic       gnt_b;
        logic       done_a;
        logic       done_b;
        logic       ce;
        logic       load;
        logic       up;
        logic [3:0] data;
        logic       busy;
        logic       owner;
    } tup_t;

    logic       clk;
    logic       rst    [2];
    logic       req_a  [2];
    logic       req_b  [2];
    logic [1:0] cmd_a  [2];
    logic [1:0] cmd_b  [2];
    logic [3:0] arg_a  [2];
    logic [3:0] arg_b  [2];
    logic       gnt_a  [2];
    logic       gnt_b  [2];
    logic       done_a [2];
    logic       done_b [2];
    logic       ce     [2];
    logic       load   [2];
    logic       up     [2];
    logic [3:0] data   [2];
    logic       busy   [2];
    logic       owner  [2];

    int   checks;
    int   passes;
    tup_t q[$];
    tup_t last_e;
    logic ptr_m [2];
    logic own_m [2];
    logic drop_a;
    logic drop_b;

    cnt_cmd_sched #(.STEP_GAP(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst[0]),
        .req_a(req_a[0]), .cmd_a(cmd_a[0]), .arg_a(arg_a[0]), .gnt_a(gnt_a[0]), .done_a(done_a[0]),
        .req_b(req_b[0]), .cmd_b(cmd_b[0]), .arg_b(arg_b[0]), .gnt_b(gnt_b[0]), .done_b(done_b[0]),
        .ctr_ce(ce[0]), .ctr_load(load[0]), .ctr_up(up[0]), .ctr_data(data[0]),
        .busy(busy[0]), .owner(owner[0])
    );

    cnt_cmd_sched #(.STEP_GAP(2), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst[1]),
        .req_a(req_a[1]), .cmd_a(cmd_a[1]), .arg_a(arg_a[1]), .gnt_a(gnt_a[1]), .done_a(done_a[1]),
        .req_b(req_b[1]), .cmd_b(cmd_b[1]), .arg_b(arg_b[1]), .gnt_b(gnt_b[1]), .done_b(done_b[1]),
        .ctr_ce(ce[1]), .ctr_load(load[1]), .ctr_up(up[1]), .ctr_data(data[1]),
        .busy(busy[1]), .owner(owner[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expand one granted command into its expected cycle sequence.
    task automatic build(input int d, input logic w, input logic [1:0] cmd, input logic [3:0] arg);
        tup_t t;
        int   gap;
        int   len;
        gap = (d == 1) ? 2 : 0;
        t = '0; t.busy = 1'b1; t.owner = w;
        if (w) t.gnt_b = 1'b1; else t.gnt_a = 1'b1;
        q.push_back(t);
        if (cmd == 2'd0) begin
            t = '0; t.busy = 1'b1; t.owner = w; t.load = 1'b1; t.data = arg;
            q.push_back(t);
        end else if (cmd != 2'd3 && arg != 4'd0) begin
            len = int'(arg) + (int'(arg) - 1) * gap;
            for (int j = 0; j < len; j++) begin
                t = '0; t.busy = 1'b1; t.owner = w;
                t.up = (cmd == 2'd1);
                t.ce = ((j % (gap + 1)) == 0);
                q.push_back(t);
            end
        end
        t = '0; t.busy = 1'b1; t.owner = w;
        if (w) t.done_b = 1'b1; else t.done_a = 1'b1;
        q.push_back(t);
        t = '0; t.owner = w;
        q.push_back(t);
    endtask

    // Advance one clock on instance d: update the model, compare, then play the requester side.
    task automatic cycle(input int d, input string tag);
        tup_t e;
        tup_t act;
        logic ra, rb, rs, w;
        logic [1:0] ca, cb;
        logic [3:0] aa, ab;
        ra = req_a[d]; rb = req_b[d]; rs = rst[d];
        ca = cmd_a[d]; cb = cmd_b[d]; aa = arg_a[d]; ab = arg_b[d];
        @(posedge clk);
        e = '0;
        if (!rs) begin
            q.delete();
            ptr_m[d] = 1'b0;
            own_m[d] = 1'b0;
        end else begin
            if (q.size() == 0 && (ra || rb)) begin
                w = (ra && rb) ? ptr_m[d] : rb;
                ptr_m[d] = ~w;
                own_m[d] = w;
                build(d, w, w ? cb : ca, w ? ab : aa);
            end
            if (q.size() != 0) e = q.pop_front();
            else e.owner = own_m[d];
        end
        #1;
        act = '{gnt_a[d], gnt_b[d], done_a[d], done_b[d], ce[d], load[d], up[d], data[d], busy[d], owner[d]};
        checks = checks + 1;
        assert (act === e) passes = passes + 1;
        else $error("FAIL %s dut=%0d t=%0t got=%b required=%b", tag, d, $time, act, e);
        last_e = e;
        // After a grant, the requester drops req in the following cycle and scrambles cmd/arg.
        if (drop_a) begin req_a[d] = 1'b0; cmd_a[d] = 2'($urandom); arg_a[d] = 4'($urandom); drop_a = 1'b0; end
        if (drop_b) begin req_b[d] = 1'b0; cmd_b[d] = 2'($urandom); arg_b[d] = 4'($urandom); drop_b = 1'b0; end
        if (e.gnt_a) drop_a = 1'b1;
        if (e.gnt_b) drop_b = 1'b1;
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b0;
        req_a[d] = 1'b0; req_b[d] = 1'b0;
        drop_a = 1'b0; drop_b = 1'b0;
        cycle(d, "reset");
        rst[d] = 1'b1;
    endtask

    task automatic issue(input int d, input logic who, input logic [1:0] cmd, input logic [3:0] arg);
        if (who) begin req_b[d] = 1'b1; cmd_b[d] = cmd; arg_b[d] = arg; end
        else     begin req_a[d] = 1'b1; cmd_a[d] = cmd; arg_a[d] = arg; end
    endtask

    task automatic wait_idle(input int d, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            cycle(d, tag);
            ok = (q.size() == 0) && !req_a[d] && !req_b[d] && !drop_a && !drop_b;
        end
        checks = checks + 1;
        assert (ok) passes = passes + 1;
        else $error("FAIL %s_timeout dut=%0d got=busy required=idle", tag, d);
    endtask

    function automatic logic [3:0] rand_arg();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 4'd0;
        if (r == 1) return 4'd15;
        return 4'($urandom);
    endfunction

    task automatic random_phase(input int d, input int n);
        int k;
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 19);
            if (k == 0) begin
                do_reset(d);
            end else begin
                if (!req_a[d] && !drop_a && $urandom_range(0, 2) == 0) issue(d, 1'b0, 2'($urandom), rand_arg());
                if (!req_b[d] && !drop_b && $urandom_range(0, 2) == 0) issue(d, 1'b1, 2'($urandom), rand_arg());
                repeat ($urandom_range(1, 12)) cycle(d, "random");
            end
        end
        wait_idle(d, "random_drain");
    endtask

    initial begin
        int pulses;
        bit hit;
        checks = 0; passes = 0;
        drop_a = 1'b0; drop_b = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; req_a[d] = 1'b0; req_b[d] = 1'b0;
            cmd_a[d] = 2'd0; cmd_b[d] = 2'd0; arg_a[d] = 4'd0; arg_b[d] = 4'd0;
            ptr_m[d] = 1'b0; own_m[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;

        // Instance with no step gap.
        do_reset(0);
        issue(0, 1'b0, 2'd0, 4'd9);                    // A LOAD 9
        wait_idle(0, "load9");
        issue(0, 1'b1, 2'd1, 4'd3);                    // B UP 3
        wait_idle(0, "up3_gap0");
        do_reset(0);
        issue(0, 1'b0, 2'd3, 4'd1); issue(0, 1'b1, 2'd3, 4'd2);  // tie right after reset
        for (int i = 0; i < 20 && !last_e.done_a; i++) cycle(0, "tie_first");
        issue(0, 1'b0, 2'd0, 4'd7);                    // A asks again while B still waits
        wait_idle(0, "alternate");
        issue(0, 1'b0, 2'd2, 4'd0);                    // A DOWN 0
        wait_idle(0, "down0");
        issue(0, 1'b0, 2'd3, 4'd5);                    // A HOLD 5
        wait_idle(0, "hold5");
        issue(0, 1'b1, 2'd1, 4'd15);                   // B UP 15, reset during the 4th pulse
        pulses = 0; hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            cycle(0, "up15");
            if (last_e.ce) pulses++;
            hit = (pulses == 4);
        end
        do_reset(0);
        issue(0, 1'b0, 2'd0, 4'd2); issue(0, 1'b1, 2'd3, 4'd0);
        wait_idle(0, "after_abort");
        issue(0, 1'b0, 2'd1, 4'd4);                    // A UP 4, B arrives mid-EXEC
        repeat (3) cycle(0, "busy_wait");
        issue(0, 1'b1, 2'd2, 4'd1);
        wait_idle(0, "busy_wait");
        random_phase(0, 40);

        // Instance with STEP_GAP = 2.
        do_reset(1);
        issue(1, 1'b1, 2'd1, 4'd3);
        wait_idle(1, "up3_gap2");
        random_phase(1, 40);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
